// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-and-add multiplier sequencer:
//   - MULT_N_DEFAULT : default operand width
//   - state_t        : sequencer state encoding (IDLE / RUN / DONE)
//   - cnt_width()    : width of the iteration counter for a given N
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_N_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter only has to hold 0..N-1; keep it at least one bit wide.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/quad_mux2.sv
// ---------------------------------------------------------------------------
// quad_mux2
// W-bit 2:1 multiplexer used to pick the addend of each multiply step.
// Ports:
//   in0 [W-1:0] : word selected when sel = 0
//   in1 [W-1:0] : word selected when sel = 1
//   sel         : select
//   y   [W-1:0] : selected word
// ---------------------------------------------------------------------------
module quad_mux2 #(
  parameter int W = 4
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
// Sequential unsigned N x N shift-and-add multiplier. One partial product
// is added per RUN cycle; the {carry, acc_hi, mult} register shifts right
// each step, so the product ends up in {acc_hi, mult}.
//
// Parameter:
//   N        : operand width (2..16)
// Ports:
//   Clock    : rising-edge clock
//   Reset    : synchronous active-high reset (priority over Start)
//   Start    : begin a multiply; only honoured in IDLE
//   A [N-1:0], B [N-1:0] : multiplicand / multiplier, captured on Start
//   Busy     : high while in RUN
//   Done     : one-cycle pulse in DONE
//   MuxSel   : addend select (multiplier LSB during RUN, else 0)
//   Product [2N-1:0] : A*B, valid from Done until the next accepted Start
//
// Optional feature: define MULT_SEQ_EARLY_EXIT_EN to leave RUN as soon as
// the remaining multiplier bits are all zero; the product is right-aligned
// in that final cycle.
// ---------------------------------------------------------------------------
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int N = MULT_N_DEFAULT
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           Busy,
  output logic           Done,
  output logic           MuxSel,
  output logic [2*N-1:0] Product
);

  localparam int CW = cnt_width(N);

  state_t          state;
  state_t          state_next;
  logic [N-1:0]    mcand;
  logic [N-1:0]    acc_hi;
  logic [N-1:0]    mult;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    addend;
  logic [N-1:0]    zero_word;
  logic [N:0]      sum;
  logic [2*N-1:0]  shifted;
  logic [2*N-1:0]  next_prod;
  logic            last_iter;

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // Multiplier bits above the one currently being consumed.
  logic [N-2:0]    rem;
  logic [CW-1:0]   shamt;
`endif

  assign zero_word = '0;

  quad_mux2 #(.W(N)) u_addend_mux (
    .in0 (zero_word),
    .in1 (mcand),
    .sel (MuxSel),
    .y   (addend)
  );

  // One multiply step: add, then shift the whole {carry, acc_hi, mult} right.
  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, addend};
    shifted = {sum, mult[N-1:1]};
`ifdef MULT_SEQ_EARLY_EXIT_EN
    last_iter = (cnt == CW'(N - 1)) || (rem == '0);
    shamt     = CW'(N - 1) - cnt;
    // Remaining steps would only add zero, so apply their shifts at once.
    next_prod = last_iter ? (shifted >> shamt) : shifted;
`else
    last_iter = (cnt == CW'(N - 1));
    next_prod = shifted;
`endif
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (Start) state_next = ST_RUN;
      ST_RUN:  if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    Busy   = (state == ST_RUN);
    Done   = (state == ST_DONE);
    MuxSel = (state == ST_RUN) && mult[0];
  end

  // Datapath: operand capture, accumulate/shift and iteration count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand  <= '0;
      acc_hi <= '0;
      mult   <= '0;
      cnt    <= '0;
`ifdef MULT_SEQ_EARLY_EXIT_EN
      rem    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            mcand  <= A;
            mult   <= B;
            acc_hi <= '0;
            cnt    <= '0;
`ifdef MULT_SEQ_EARLY_EXIT_EN
            rem    <= B[N-1:1];
`endif
          end
        end
        ST_RUN: begin
          {acc_hi, mult} <= next_prod;
          cnt            <= cnt + 1'b1;
`ifdef MULT_SEQ_EARLY_EXIT_EN
          rem            <= rem >> 1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign Product = {acc_hi, mult};

endmodule
